// File: rtl/gcd_arbiter_pkg.sv
// Shared definitions for the two-requester GCD engine arbiter: FSM encoding,
// datapath widths and the default watchdog limit.
package gcd_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      ISSUE = 2'b01,
      WAIT  = 2'b10,
      REPLY = 2'b11
   } state_e;

   localparam int unsigned TIMEOUT_DEFAULT = 300;
   localparam int          CNT_W           = 10;
   localparam int          DATA_W          = 8;

   // One-hot grant vector for a requester id.
   function automatic logic [1:0] id_onehot(input logic id);
      return id ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/gcd_arbiter_rr_pick2.sv
// Two-way round-robin picker: the favoured requester wins only on contention,
// a lone request always wins.
module rr_pick2 (
   input  logic [1:0] req,
   input  logic       ptr,
   output logic       valid,
   output logic       id
);

   always_comb begin
      valid = |req;
      id    = (req == 2'b11) ? ptr : req[1];
   end

endmodule

// File: rtl/gcd_arbiter.sv
// Arbitrates two requesters onto one shared GCD engine, one job at a time,
// with a watchdog that aborts a job the engine never finishes.
module gcd_arbiter
   import gcd_arbiter_pkg::*;
#(
   parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        REQ0,
   input  logic        REQ1,
   input  logic [7:0]  A0,
   input  logic [7:0]  B0,
   input  logic [7:0]  A1,
   input  logic [7:0]  B1,
   output logic        GNT0,
   output logic        GNT1,
   output logic        RES_VLD,
   output logic        RES_ID,
   output logic [7:0]  RES_Y,
   output logic        RES_ERR,
   output logic        RES_TOUT,
   output logic        BUSY,
   output logic        ENG_START,
   output logic [7:0]  ENG_A,
   output logic [7:0]  ENG_B,
   input  logic [7:0]  ENG_Y,
   input  logic        ENG_DONE,
   input  logic        ENG_ERROR,
   output logic [1:0]  DBG_STATE
);

   localparam logic [CNT_W-1:0] TOUT_LAST = CNT_W'(TIMEOUT - 1);

   state_e              state_q, state_d;
   logic                ptr_q, ptr_d;
   logic                id_q, id_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [DATA_W-1:0]   eng_a_q, eng_a_d;
   logic [DATA_W-1:0]   eng_b_q, eng_b_d;
   logic                eng_start_q, eng_start_d;
   logic [1:0]          gnt_q, gnt_d;
   logic                res_vld_q, res_vld_d;
   logic                res_id_q, res_id_d;
   logic [DATA_W-1:0]   res_y_q, res_y_d;
   logic                res_err_q, res_err_d;
   logic                res_tout_q, res_tout_d;
   logic                busy_q, busy_d;

   logic                pick_valid;
   logic                pick_id;

   rr_pick2 u_pick (
      .req   ({REQ1, REQ0}),
      .ptr   (ptr_q),
      .valid (pick_valid),
      .id    (pick_id)
   );

   // Every output is a flop loaded with the value it must show in the state
   // being entered, so outputs line up with state_q without combinational paths.
   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      id_d        = id_q;
      cnt_d       = cnt_q;
      eng_a_d     = eng_a_q;
      eng_b_d     = eng_b_q;
      eng_start_d = 1'b0;
      gnt_d       = 2'b00;
      res_vld_d   = 1'b0;
      res_id_d    = 1'b0;
      res_y_d     = '0;
      res_err_d   = 1'b0;
      res_tout_d  = 1'b0;

      case (state_q)
         IDLE: begin
            if (pick_valid) begin
               state_d     = ISSUE;
               id_d        = pick_id;
               gnt_d       = id_onehot(pick_id);
               eng_start_d = 1'b1;
               eng_a_d     = pick_id ? A1 : A0;
               eng_b_d     = pick_id ? B1 : B0;
            end
         end
         ISSUE: begin
            cnt_d   = '0;
            state_d = WAIT;
         end
         WAIT: begin
            // A DONE landing on the last watchdog cycle still wins.
            if (ENG_DONE) begin
               state_d   = REPLY;
               res_vld_d = 1'b1;
               res_id_d  = id_q;
               res_y_d   = ENG_Y;
               res_err_d = ENG_ERROR;
            end else if (cnt_q == TOUT_LAST) begin
               state_d    = REPLY;
               res_vld_d  = 1'b1;
               res_id_d   = id_q;
               res_err_d  = 1'b1;
               res_tout_d = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         REPLY: begin
            ptr_d   = ~id_q;
            state_d = IDLE;
            eng_a_d = '0;
            eng_b_d = '0;
         end
         default: state_d = IDLE;
      endcase

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q     <= IDLE;
         ptr_q       <= 1'b0;
         id_q        <= 1'b0;
         cnt_q       <= '0;
         eng_a_q     <= '0;
         eng_b_q     <= '0;
         eng_start_q <= 1'b0;
         gnt_q       <= 2'b00;
         res_vld_q   <= 1'b0;
         res_id_q    <= 1'b0;
         res_y_q     <= '0;
         res_err_q   <= 1'b0;
         res_tout_q  <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         id_q        <= id_d;
         cnt_q       <= cnt_d;
         eng_a_q     <= eng_a_d;
         eng_b_q     <= eng_b_d;
         eng_start_q <= eng_start_d;
         gnt_q       <= gnt_d;
         res_vld_q   <= res_vld_d;
         res_id_q    <= res_id_d;
         res_y_q     <= res_y_d;
         res_err_q   <= res_err_d;
         res_tout_q  <= res_tout_d;
         busy_q      <= busy_d;
      end
   end

   assign GNT0      = gnt_q[0];
   assign GNT1      = gnt_q[1];
   assign RES_VLD   = res_vld_q;
   assign RES_ID    = res_id_q;
   assign RES_Y     = res_y_q;
   assign RES_ERR   = res_err_q;
   assign RES_TOUT  = res_tout_q;
   assign BUSY      = busy_q;
   assign ENG_START = eng_start_q;
   assign ENG_A     = eng_a_q;
   assign ENG_B     = eng_b_q;
   assign DBG_STATE = state_q;

endmodule

// File: tb/tb_gcd_arbiter.sv
// Directed bench for gcd_arbiter: the engine is played by hand from the
// stimulus sequence, results are also tracked through an expected queue.
module tb_gcd_arbiter;
   import gcd_arbiter_pkg::*;

   localparam int TOUT = 300;

   logic       clk = 1'b0;
   logic       rst;
   logic       req0, req1;
   logic [7:0] a0, b0, a1, b1;
   logic       gnt0, gnt1, res_vld, res_id, res_err, res_tout, busy, eng_start;
   logic [7:0] res_y, eng_a, eng_b, eng_y;
   logic       eng_done, eng_error;
   logic [1:0] dbg_state;

   int checks = 0;
   int errors = 0;
   int gnt0_n = 0, gnt1_n = 0, res_n = 0, idle_dirty = 0;
   logic [10:0] exp_q[$];

   gcd_arbiter #(.TIMEOUT(TOUT)) dut (
      .CLK(clk), .RST(rst), .REQ0(req0), .REQ1(req1),
      .A0(a0), .B0(b0), .A1(a1), .B1(b1),
      .GNT0(gnt0), .GNT1(gnt1), .RES_VLD(res_vld), .RES_ID(res_id),
      .RES_Y(res_y), .RES_ERR(res_err), .RES_TOUT(res_tout), .BUSY(busy),
      .ENG_START(eng_start), .ENG_A(eng_a), .ENG_B(eng_b),
      .ENG_Y(eng_y), .ENG_DONE(eng_done), .ENG_ERROR(eng_error),
      .DBG_STATE(dbg_state)
   );

   // clock / reset
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
      $fatal(1, "time limit");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] all_out();
      return {gnt1, gnt0, res_vld, res_id, res_y, res_err, res_tout, busy,
              eng_start, eng_a, eng_b};
   endfunction

   // scoreboard: result pulses against the expected queue, idle-zero rule, pulse counts
   always @(negedge clk) begin
      logic [10:0] e;
      if (gnt0) gnt0_n++;
      if (gnt1) gnt1_n++;
      if (res_vld) begin
         res_n++;
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL sb_unexpected: observed id=%0d y=%0d with no expected result", res_id, res_y);
         end else begin
            e = exp_q.pop_front();
            chk("sb_result", {21'd0, res_id, res_y, res_err, res_tout}, {21'd0, e});
         end
      end else if ({res_id, res_y, res_err, res_tout} != 11'd0) begin
         idle_dirty++;
      end
   end

   // driver tasks
   task automatic wait_start(input string tag, input logic id, input logic [7:0] a, input logic [7:0] b);
      int n = 0;
      while (!eng_start && n < 10) begin
         step();
         n++;
      end
      chk({tag, "_start"}, {31'd0, eng_start}, 32'd1);
      chk({tag, "_gnt"}, {30'd0, gnt1, gnt0}, id ? 32'd2 : 32'd1);
      chk({tag, "_ops"}, {16'd0, eng_a, eng_b}, {16'd0, a, b});
      chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
   endtask

   task automatic run_job(input string tag, input logic id, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] y, input logic err, input bit drop, input int delay);
      wait_start(tag, id, a, b);
      if (drop) begin
         req0 = 1'b0;
         req1 = 1'b0;
      end
      exp_q.push_back({id, y, err, 1'b0});
      step();
      chk({tag, "_hold"}, {13'd0, gnt1, gnt0, eng_start, eng_a, eng_b}, {16'd0, a, b});
      chk({tag, "_wait_st"}, {30'd0, dbg_state}, 32'd2);
      repeat (delay) step();
      eng_done  = 1'b1;
      eng_y     = y;
      eng_error = err;
      step();
      eng_done  = 1'b0;
      eng_y     = 8'd0;
      eng_error = 1'b0;
      chk({tag, "_res"}, {20'd0, res_vld, res_id, res_y, res_err, res_tout},
          {20'd0, 1'b1, id, y, err, 1'b0});
      step();
      chk({tag, "_idle"}, {30'd0, res_vld, busy}, 32'd0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
   endtask

   initial begin
      int n;
      rst = 1'b1;
      req0 = 1'b0; req1 = 1'b0;
      a0 = 8'd0; b0 = 8'd0; a1 = 8'd0; b1 = 8'd0;
      eng_y = 8'd0; eng_done = 1'b0; eng_error = 1'b0;

      // reset values, with request and stale DONE present during reset
      req0 = 1'b1;
      eng_done = 1'b1;
      step();
      step();
      chk("rst_outputs", all_out(), 32'd0);
      chk("rst_state", {30'd0, dbg_state}, 32'd0);
      req0 = 1'b0;
      rst  = 1'b0;
      step();
      eng_done = 1'b0;
      chk("idle_done_ignored", all_out(), 32'd0);

      // single request 12,18 -> 6
      req0 = 1'b1; a0 = 8'd12; b0 = 8'd18;
      run_job("single", 1'b0, 8'd12, 8'd18, 8'd6, 1'b0, 1'b1, 3);

      // zero operand, engine error is passed through
      req1 = 1'b1; a1 = 8'd0; b1 = 8'd5;
      run_job("zero_op", 1'b1, 8'd0, 8'd5, 8'd0, 1'b1, 1'b1, 1);

      // contention from reset: 0,1,0,1
      do_reset();
      req0 = 1'b1; a0 = 8'd8; b0 = 8'd12;
      req1 = 1'b1; a1 = 8'd9; b1 = 8'd6;
      run_job("cont0", 1'b0, 8'd8, 8'd12, 8'd4, 1'b0, 1'b0, 2);
      run_job("cont1", 1'b1, 8'd9, 8'd6, 8'd3, 1'b0, 1'b0, 2);
      run_job("cont2", 1'b0, 8'd8, 8'd12, 8'd4, 1'b0, 1'b0, 0);
      run_job("cont3", 1'b1, 8'd9, 8'd6, 8'd3, 1'b0, 1'b1, 4);

      // timeout: no DONE at all
      req0 = 1'b1; a0 = 8'd7; b0 = 8'd14;
      wait_start("tout", 1'b0, 8'd7, 8'd14);
      req0 = 1'b0;
      exp_q.push_back({1'b0, 8'd0, 1'b1, 1'b1});
      repeat (150) step();
      chk("tout_midwait", {14'd0, busy, res_vld, eng_a, eng_b}, {14'd0, 1'b1, 1'b0, 8'd7, 8'd14});
      n = 150;
      while (!res_vld && n < TOUT + 20) begin
         step();
         n++;
      end
      chk("tout_latency", n, TOUT + 1);
      chk("tout_res", {20'd0, res_vld, res_id, res_y, res_err, res_tout}, {20'd0, 1'b1, 1'b0, 8'd0, 1'b1, 1'b1});
      step();
      chk("tout_idle", {30'd0, res_vld, busy}, 32'd0);

      // next request after a timeout is served normally
      req1 = 1'b1; a1 = 8'd21; b1 = 8'd14;
      run_job("after_tout", 1'b1, 8'd21, 8'd14, 8'd7, 1'b0, 1'b1, 0);

      // DONE on the very cycle the watchdog expires counts as DONE
      req0 = 1'b1; a0 = 8'd5; b0 = 8'd10;
      wait_start("edge", 1'b0, 8'd5, 8'd10);
      req0 = 1'b0;
      exp_q.push_back({1'b0, 8'd5, 1'b0, 1'b0});
      repeat (TOUT) step();
      chk("edge_pre", {30'd0, res_vld, busy}, 32'd1);
      eng_done = 1'b1; eng_y = 8'd5;
      step();
      eng_done = 1'b0; eng_y = 8'd0;
      chk("edge_res", {20'd0, res_vld, res_id, res_y, res_err, res_tout}, {20'd0, 1'b1, 1'b0, 8'd5, 1'b0, 1'b0});
      step();
      chk("edge_idle", {30'd0, res_vld, busy}, 32'd0);

      // reset in WAIT abandons the job; late DONE is ignored
      req0 = 1'b1; a0 = 8'd3; b0 = 8'd9;
      wait_start("rstmid", 1'b0, 8'd3, 8'd9);
      req0 = 1'b0;
      step();
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("rstmid_out", all_out(), 32'd0);
      chk("rstmid_state", {30'd0, dbg_state}, 32'd0);
      eng_done = 1'b1; eng_y = 8'd3;
      step();
      eng_done = 1'b0; eng_y = 8'd0;
      chk("rstmid_stale_done", all_out(), 32'd0);
      step();
      chk("rstmid_quiet", all_out(), 32'd0);
      req0 = 1'b1; a0 = 8'd4; b0 = 8'd6;
      req1 = 1'b1; a1 = 8'd10; b1 = 8'd15;
      run_job("rstmid_first", 1'b0, 8'd4, 8'd6, 8'd2, 1'b0, 1'b1, 1);

      step();
      step();
      // final report
      chk("gnt0_pulses", gnt0_n, 32'd7);
      chk("gnt1_pulses", gnt1_n, 32'd4);
      chk("res_pulses", res_n, 32'd10);
      chk("res_zero_when_idle", idle_dirty, 32'd0);
      chk("sb_drained", exp_q.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/gcd_arbiter.md
GCD_ARBITER -- requirements
Module: gcd_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 300, SHALL set the maximum number of cycles spent in WAIT before the job is aborted; legal range is 2..1023.
REQ-002 CLK  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-003 RST  input  1  SHALL be the reset, synchronous and active-high.
REQ-004 REQ0/REQ1  input  1 each  SHALL be the job request from requester 0/1; held high with operands stable until the matching GNT.
REQ-005 A0,B0/A1,B1  input  8 each  SHALL be the operands of requester 0/1.
REQ-006 GNT0/GNT1  output  1 each  SHALL be a one-cycle pulse meaning the operands are captured; the requester may drop REQ next cycle.
REQ-007 RES_VLD  output  1  SHALL be a one-cycle result-valid pulse.
REQ-008 RES_ID  output  1  SHALL be the requester owning the result, valid with RES_VLD.
REQ-009 RES_Y  output  8  SHALL be the GCD result, valid with RES_VLD.
REQ-010 RES_ERR  output  1  SHALL be the engine error or timeout flag, valid with RES_VLD.
REQ-011 RES_TOUT  output  1  SHALL be the timeout flag, valid with RES_VLD.
REQ-012 BUSY  output  1  SHALL be high in every state except IDLE.
REQ-013 ENG_START  output  1, ENG_A/ENG_B  output  8 each  SHALL drive the shared GCD engine's START, A and B.
REQ-014 ENG_Y  input  8, ENG_DONE  input  1, ENG_ERROR  input  1  SHALL be the engine's Y, DONE and ERROR.

Function
REQ-015 The FSM SHALL have states IDLE, ISSUE, WAIT, REPLY, with all outputs registered.
REQ-016 IDLE: if any REQ is high, the FSM SHALL select one requester per REQ-021, latch its A/B and ID, and move to ISSUE; otherwise it stays in IDLE.
REQ-017 ISSUE (one cycle): the FSM SHALL assert GNT[ID]=1 and ENG_START=1, drive ENG_A/ENG_B from the latched operands, clear the watchdog counter, and move to WAIT.
REQ-018 WAIT: ENG_A/ENG_B SHALL stay stable.
- On ENG_DONE=1 it SHALL latch ENG_Y and ENG_ERROR and move to REPLY.
- Otherwise, when the counter reaches TIMEOUT-1, it SHALL move to REPLY with Y=0, ERR=1, TOUT=1.
- Otherwise the counter increments.
REQ-019 REPLY (one cycle): the FSM SHALL assert RES_VLD with the latched ID/Y/ERR/TOUT, update the priority pointer, and move to IDLE.
REQ-020 ENG_DONE SHALL be ignored in IDLE, ISSUE and REPLY; ENG_DONE coinciding with the timeout cycle SHALL count as DONE.
REQ-021 Arbitration SHALL be round-robin.
- The pointer names the favoured requester; after reset it favours requester 0.
- If both REQ are high, the favoured requester wins; a single REQ wins regardless of the pointer.
- After REPLY, the pointer favours the requester not just served.
REQ-022 Minimum latency SHALL be: REQ sampled in IDLE at edge k -> GNT/ENG_START during cycle k+1 -> RES_VLD one cycle after the ENG_DONE edge.
REQ-023 Zero operands SHALL be forwarded unchanged; the arbiter SHALL report the engine's ERROR and not filter it.
REQ-024 At most one job SHALL be outstanding; REQ during BUSY SHALL be held off with no GNT.
REQ-025 RES_* outputs SHALL be 0 whenever RES_VLD=0.

Reset
REQ-026 RST=1 at a clock edge SHALL force state IDLE, pointer to requester 0, counter 0, and all outputs 0 (GNT*, RES_*, ENG_*, BUSY).
REQ-027 Reset during ISSUE/WAIT/REPLY SHALL abandon the job without RES_VLD; a stale ENG_DONE after reset SHALL be ignored per REQ-020.

Structure
REQ-028 State encodings (IDLE=2'b00, ISSUE=2'b01, WAIT=2'b10, REPLY=2'b11) and the default TIMEOUT SHALL live in the shared GCD package.
REQ-029 Round-robin selection SHALL be one sub-module, rr_pick2 (inputs req[1:0], ptr; outputs valid, id); everything else is in gcd_arbiter.
REQ-030 The watchdog counter SHALL be 10 bits.

Verification
REQ-031 Single request: REQ0=1, A0=12, B0=18 -> one GNT0 pulse, one ENG_START with ENG_A=12, ENG_B=18; engine DONE with Y=6 -> RES_VLD, RES_ID=0, RES_Y=6, RES_ERR=0.
REQ-032 Contention: REQ0 and REQ1 held high after reset (A0=8,B0=12; A1=9,B1=6) -> result order ID 0 (Y=4), 1 (Y=3), 0, 1; no GNT while BUSY.
REQ-033 Zero operand: REQ1, A1=0, B1=5, engine returns ERROR=1 -> RES_VLD, RES_ID=1, RES_ERR=1, RES_TOUT=0.
REQ-034 Timeout: engine model never asserts DONE -> RES_VLD with RES_ERR=1, RES_TOUT=1, RES_Y=0 exactly TIMEOUT+1 cycles after ENG_START; the next request is then accepted normally.
REQ-035 Reset mid-job: RST pulsed during WAIT, then ENG_DONE pulsed -> all outputs 0, no RES_VLD, BUSY=0; simultaneous REQ0/REQ1 after reset -> requester 0 granted first.
